trans_issuer: RTL

TRANS_ISSUER -- requirements
Module: trans_issuer

---
 rtl/trans_issuer.sv | 77 +++++++
 1 files changed

// File: rtl/trans_issuer.sv
// rtl/trans_issuer.sv - Burst address issuer: expands one command into an AXIS stream of incrementing virtual addresses.
module trans_issuer #(
  parameter int VADDR_W = 8,
  parameter int BLOCK_W = 8,
  parameter int LEN_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BLOCK_W-1:0] cmd_block,
  input  logic [VADDR_W-1:0] cmd_vaddr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [VADDR_W-1:0] m_tdata,
  output logic [BLOCK_W-1:0] m_tuser,
  output logic               m_tlast,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             accept;
  logic             beat_hs;

  // cmd_ready decodes state only, so there is no path from m_tready.
  assign cmd_ready = i_rst_n & (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign m_tvalid  = (state == ST_STREAM);
  assign o_busy    = (state == ST_STREAM);
  assign m_tlast   = m_tvalid & (beat_cnt == len_q);
  assign beat_hs   = m_tvalid & m_tready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            len_q    <= cmd_len;
            beat_cnt <= '0;
            m_tdata  <= cmd_vaddr;
            m_tuser  <= cmd_block;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_hs) begin
            // The counter stops at len on the final beat, so len=all-ones never overflows.
            if (m_tlast) begin
              state  <= ST_IDLE;
              o_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
              m_tdata  <= m_tdata + VADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
